// File: rtl/scoreboard_controller_multilevel_if.sv
// rtl/scoreboard_controller_multilevel_if.sv - button/display bundle for the multi-level scoreboard
// seg7_hiscore exists only when SCOREBOARD_HISCORE_EN is defined.
interface scoreboard_controller_multilevel_if #(
  parameter int PT_DIGITS = 3
);
  logic                   St;
  logic                   Pt;
  logic                   Done;
  logic                   Win;
  logic [7*PT_DIGITS-1:0] seg7_points;
  logic [13:0]            seg7_timer;
  logic [6:0]             seg7_level;
`ifdef SCOREBOARD_HISCORE_EN
  logic [7*PT_DIGITS-1:0] seg7_hiscore;

  modport master (output St, Pt,
                  input  Done, Win, seg7_points, seg7_timer, seg7_level, seg7_hiscore);
  modport slave  (input  St, Pt,
                  output Done, Win, seg7_points, seg7_timer, seg7_level, seg7_hiscore);
`else
  modport master (output St, Pt,
                  input  Done, Win, seg7_points, seg7_timer, seg7_level);
  modport slave  (input  St, Pt,
                  output Done, Win, seg7_points, seg7_timer, seg7_level);
`endif
endinterface

// File: rtl/scoreboard_controller_multilevel.sv
// rtl/scoreboard_controller_multilevel.sv - multi-level BCD scoreboard with countdown timer
// Optional high-score register and display enabled by SCOREBOARD_HISCORE_EN.
module scoreboard_controller_multilevel #(
  parameter int PT_DIGITS     = 3,
  parameter int TIMER_SEC     = 30,
  parameter int TICKS_PER_SEC = 1,
  parameter int NUM_LEVELS    = 3,
  parameter int LEVEL_TARGET  = 10
) (
  input logic clk,
  input logic rst,
  scoreboard_controller_multilevel_if.slave sb
);

  localparam int PW = 4 * PT_DIGITS;
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    TIMER_BCD  = {4'(TIMER_SEC / 10), 4'(TIMER_SEC % 10)};
  localparam logic [3:0]    LEVEL_LAST = 4'(NUM_LEVELS);
  localparam logic [8:0]    TARGET     = 9'(LEVEL_TARGET);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          pt_q;
  logic [PW-1:0] points_q, points_d;
  logic [7:0]    round_q, round_d;
  logic [3:0]    level_q, level_d;
  logic [7:0]    timer_q, timer_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          done_q, done_d;
  logic          win_q, win_d;

  logic          hit;
  logic          load;
  logic [PW-1:0] points_add;
  logic [8:0]    round_sum;
  logic [7:0]    round_add;
  logic          level_clear;
  logic [7:0]    timer_dec;

  assign hit = sb.Pt & ~pt_q;

  // Level weight is a single BCD digit, so each digit carries at most one; carry out saturates.
  always_comb begin : bcd_add
    logic [4:0] sum;
    logic [3:0] carry;
    carry      = level_q;
    points_add = '0;
    for (int i = 0; i < PT_DIGITS; i++) begin
      sum = {1'b0, points_q[4*i +: 4]} + {1'b0, carry};
      if (sum > 5'd9) begin
        points_add[4*i +: 4] = 4'(sum - 5'd10);
        carry                = 4'd1;
      end else begin
        points_add[4*i +: 4] = sum[3:0];
        carry                = 4'd0;
      end
    end
    if (carry != 4'd0) points_add = {PT_DIGITS{4'd9}};
  end

  assign round_sum   = {1'b0, round_q} + {5'b0, level_q};
  assign round_add   = round_sum[8] ? 8'hFF : round_sum[7:0];
  assign level_clear = ({1'b0, round_add} >= TARGET);
  assign timer_dec   = (timer_q[3:0] == 4'd0) ? {timer_q[7:4] - 4'd1, 4'd9}
                                              : {timer_q[7:4], timer_q[3:0] - 4'd1};

  always_comb begin
    state_d  = state_q;
    points_d = points_q;
    round_d  = round_q;
    level_d  = level_q;
    timer_d  = timer_q;
    tick_d   = tick_q;
    done_d   = done_q;
    win_d    = win_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (sb.St) begin
          load    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (hit) begin
          points_d = points_add;
          round_d  = round_add;
        end
        // A level clear takes priority over a timer wrap on the same edge.
        if (hit && level_clear) begin
          if (level_q < LEVEL_LAST) begin
            level_d = level_q + 4'd1;
            timer_d = TIMER_BCD;
            tick_d  = '0;
            round_d = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            win_d   = 1'b1;
          end
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          timer_d = timer_dec;
          if (timer_q == 8'h01) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      points_d = '0;
      round_d  = '0;
      level_d  = 4'd1;
      timer_d  = TIMER_BCD;
      tick_d   = '0;
      done_d   = 1'b0;
      win_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pt_q     <= 1'b0;
      points_q <= '0;
      round_q  <= '0;
      level_q  <= 4'd1;
      timer_q  <= TIMER_BCD;
      tick_q   <= '0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pt_q     <= sb.Pt;
      points_q <= points_d;
      round_q  <= round_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      win_q    <= win_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  for (genvar g = 0; g < PT_DIGITS; g++) begin : g_pts
    assign sb.seg7_points[7*g +: 7] = seg7(points_q[4*g +: 4]);
  end

  assign sb.Done       = done_q;
  assign sb.Win        = win_q;
  assign sb.seg7_timer = {seg7(timer_q[7:4]), seg7(timer_q[3:0])};
  assign sb.seg7_level = seg7(level_q);

`ifdef SCOREBOARD_HISCORE_EN
  // Power-up value; only the first rst clears, later resets keep the record.
  logic [PW-1:0] hiscore_q = '0;
  logic          hs_init_q = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (!hs_init_q) begin
        hiscore_q <= '0;
        hs_init_q <= 1'b1;
      end
    end else if (state_q == S_PLAY && state_d == S_DONE && points_d > hiscore_q) begin
      hiscore_q <= points_d;
    end
  end

  for (genvar g = 0; g < PT_DIGITS; g++) begin : g_hs
    assign sb.seg7_hiscore[7*g +: 7] = seg7(hiscore_q[4*g +: 4]);
  end
`endif

endmodule

// File: tb/tb_scoreboard_controller_multilevel.sv
// tb/tb_scoreboard_controller_multilevel.sv - scoreboard-style bench over four parameter sets
module tb_scoreboard_controller_multilevel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;

  scoreboard_controller_multilevel_if #(.PT_DIGITS(3)) if_a ();
  scoreboard_controller_multilevel_if #(.PT_DIGITS(3)) if_b ();
  scoreboard_controller_multilevel_if #(.PT_DIGITS(3)) if_c ();
  scoreboard_controller_multilevel_if #(.PT_DIGITS(1)) if_d ();

  scoreboard_controller_multilevel #(.TICKS_PER_SEC(1000)) u_a (
    .clk(clk), .rst(rst_a), .sb(if_a.slave));
  scoreboard_controller_multilevel #(.TIMER_SEC(2), .TICKS_PER_SEC(4)) u_b (
    .clk(clk), .rst(rst_b), .sb(if_b.slave));
  scoreboard_controller_multilevel #(.TIMER_SEC(2), .TICKS_PER_SEC(4), .NUM_LEVELS(2),
                                     .LEVEL_TARGET(2)) u_c (
    .clk(clk), .rst(rst_c), .sb(if_c.slave));
  scoreboard_controller_multilevel #(.PT_DIGITS(1), .TIMER_SEC(1), .TICKS_PER_SEC(40),
                                     .NUM_LEVELS(1), .LEVEL_TARGET(255)) u_d (
    .clk(clk), .rst(rst_d), .sb(if_d.slave));

  typedef struct {
    int          inst;
    string       name;
    logic        done;
    logic        win;
    logic [27:0] pts;
    logic [13:0] tmr;
    logic [6:0]  lvl;
    bit          chk_tmr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'h3F; 1: seg = 7'h06; 2: seg = 7'h5B; 3: seg = 7'h4F; 4: seg = 7'h66;
      5: seg = 7'h6D; 6: seg = 7'h7D; 7: seg = 7'h07; 8: seg = 7'h7F; 9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] p3(input int a, input int b, input int c);
    p3 = {7'h00, seg(a), seg(b), seg(c)};
  endfunction

  function automatic logic [27:0] p1(input int a);
    p1 = {21'h0, seg(a)};
  endfunction

  function automatic logic [13:0] tm(input int a, input int b);
    tm = {seg(a), seg(b)};
  endfunction

  task automatic expect_out(input int inst, input string name, input logic done, input logic win,
                            input logic [27:0] pts, input logic [13:0] tmr, input logic [6:0] lvl,
                            input bit chk_tmr);
    exp_t e;
    e.inst = inst; e.name = name; e.done = done; e.win = win;
    e.pts = pts; e.tmr = tmr; e.lvl = lvl; e.chk_tmr = chk_tmr;
    exp_q.push_back(e);
  endtask

  exp_t        mon_e;
  logic        a_done, a_win;
  logic [27:0] a_pts;
  logic [13:0] a_tmr;
  logic [6:0]  a_lvl;
  bit          mon_ok;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      a_done = 1'b0; a_win = 1'b0; a_pts = '0; a_tmr = '0; a_lvl = '0;
      case (mon_e.inst)
        0: begin a_done = if_a.Done; a_win = if_a.Win; a_pts = {7'h0, if_a.seg7_points};
                 a_tmr = if_a.seg7_timer; a_lvl = if_a.seg7_level; end
        1: begin a_done = if_b.Done; a_win = if_b.Win; a_pts = {7'h0, if_b.seg7_points};
                 a_tmr = if_b.seg7_timer; a_lvl = if_b.seg7_level; end
        2: begin a_done = if_c.Done; a_win = if_c.Win; a_pts = {7'h0, if_c.seg7_points};
                 a_tmr = if_c.seg7_timer; a_lvl = if_c.seg7_level; end
        3: begin a_done = if_d.Done; a_win = if_d.Win; a_pts = {21'h0, if_d.seg7_points};
                 a_tmr = if_d.seg7_timer; a_lvl = if_d.seg7_level; end
`ifdef SCOREBOARD_HISCORE_EN
        4: a_pts = {21'h0, if_d.seg7_hiscore};
`endif
        default: ;
      endcase
      checks++;
      if (mon_e.inst == 4)
        mon_ok = (a_pts === mon_e.pts);
      else
        mon_ok = (a_done === mon_e.done) && (a_win === mon_e.win) && (a_pts === mon_e.pts) &&
                 (a_lvl === mon_e.lvl) && (!mon_e.chk_tmr || a_tmr === mon_e.tmr);
      if (!mon_ok) begin
        errors++;
        $display("FAIL %s: got done=%0b win=%0b pts=%h tmr=%h lvl=%h want done=%0b win=%0b pts=%h tmr=%h lvl=%h",
                 mon_e.name, a_done, a_win, a_pts, a_tmr, a_lvl,
                 mon_e.done, mon_e.win, mon_e.pts, mon_e.tmr, mon_e.lvl);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_st(input int i, input logic v);
    case (i)
      0: if_a.St = v; 1: if_b.St = v; 2: if_c.St = v; default: if_d.St = v;
    endcase
  endtask

  task automatic set_pt(input int i, input logic v);
    case (i)
      0: if_a.Pt = v; 1: if_b.Pt = v; 2: if_c.Pt = v; default: if_d.Pt = v;
    endcase
  endtask

  task automatic set_rst(input int i, input logic v);
    case (i)
      0: rst_a = v; 1: rst_b = v; 2: rst_c = v; default: rst_d = v;
    endcase
  endtask

  task automatic do_reset(input int i);
    set_rst(i, 1'b1); step(); set_rst(i, 1'b0);
  endtask

  task automatic start(input int i);
    set_st(i, 1'b1); step(); set_st(i, 1'b0); step();
  endtask

  task automatic pulse(input int i);
    set_pt(i, 1'b1); step(); set_pt(i, 1'b0); step();
  endtask

  initial begin
    if_a.St = 0; if_a.Pt = 0; if_b.St = 0; if_b.Pt = 0;
    if_c.St = 0; if_c.Pt = 0; if_d.St = 0; if_d.Pt = 0;

    do_reset(0);
    checks++;
    if (if_a.Done !== 1'b0 || if_a.Win !== 1'b0 || {7'h0, if_a.seg7_points} !== p3(0,0,0) ||
        if_a.seg7_timer !== tm(3,0) || if_a.seg7_level !== seg(1)) begin
      errors++;
      $display("FAIL a_reset_direct: done=%0b win=%0b pts=%h tmr=%h lvl=%h",
               if_a.Done, if_a.Win, if_a.seg7_points, if_a.seg7_timer, if_a.seg7_level);
    end
    expect_out(0, "a_reset", 0, 0, p3(0,0,0), tm(3,0), seg(1), 1);
    start(0);
    repeat (3) pulse(0);
    expect_out(0, "a_three_hits", 0, 0, p3(0,0,3), tm(3,0), seg(1), 1);
    do_reset(0);
    expect_out(0, "a_reset_mid_play", 0, 0, p3(0,0,0), tm(3,0), seg(1), 1);
    pulse(0);
    expect_out(0, "a_hit_in_idle", 0, 0, p3(0,0,0), tm(3,0), seg(1), 1);
    start(0);
    repeat (10) pulse(0);
    expect_out(0, "a_level_clear", 0, 0, p3(0,1,0), tm(3,0), seg(2), 1);
    set_pt(0, 1'b1); steps(5); set_pt(0, 1'b0); step();
    expect_out(0, "a_held_one_hit", 0, 0, p3(0,1,2), tm(3,0), seg(2), 1);
    set_st(0, 1'b1); steps(2); set_st(0, 1'b0); step();
    expect_out(0, "a_st_in_play", 0, 0, p3(0,1,2), tm(3,0), seg(2), 1);
    pulse(0);
    expect_out(0, "a_still_playing", 0, 0, p3(0,1,4), tm(3,0), seg(2), 1);

    do_reset(1);
    start(1);
    expect_out(1, "b_entry", 0, 0, p3(0,0,0), tm(0,2), seg(1), 1);
    steps(4);
    expect_out(1, "b_edge4", 0, 0, p3(0,0,0), tm(0,1), seg(1), 1);
    steps(3);
    expect_out(1, "b_edge7", 0, 0, p3(0,0,0), tm(0,1), seg(1), 1);
    step();
    checks++;
    if (if_b.Done !== 1'b1 || if_b.Win !== 1'b0 || if_b.seg7_timer !== tm(0,0)) begin
      errors++;
      $display("FAIL b_expired_direct: done=%0b win=%0b tmr=%h",
               if_b.Done, if_b.Win, if_b.seg7_timer);
    end
    expect_out(1, "b_edge8_done", 1, 0, p3(0,0,0), tm(0,0), seg(1), 1);
    steps(3);
    expect_out(1, "b_frozen", 1, 0, p3(0,0,0), tm(0,0), seg(1), 1);
    set_st(1, 1'b1); step();
    expect_out(1, "b_restart", 0, 0, p3(0,0,0), tm(0,2), seg(1), 1);
    set_st(1, 1'b0);

    do_reset(2);
    start(2);
    pulse(2); pulse(2);
    expect_out(2, "c_level2", 0, 0, p3(0,0,2), tm(0,2), seg(2), 1);
    pulse(2);
    expect_out(2, "c_win", 1, 1, p3(0,0,4), tm(0,2), seg(2), 1);
    start(2);
    expect_out(2, "c_restart", 0, 0, p3(0,0,0), tm(0,2), seg(1), 1);
    pulse(2); pulse(2);
    steps(6);
    expect_out(2, "c_before_expiry", 0, 0, p3(0,0,2), tm(0,1), seg(2), 1);
    set_pt(2, 1'b1); step(); set_pt(2, 1'b0);
    expect_out(2, "c_hit_at_expiry", 1, 1, p3(0,0,4), tm(0,0), seg(2), 0);

    do_reset(3);
    start(3);
    repeat (9) pulse(3);
    expect_out(3, "d_nine", 0, 0, p1(9), tm(0,1), seg(1), 1);
    repeat (3) pulse(3);
    expect_out(3, "d_saturate", 0, 0, p1(9), tm(0,1), seg(1), 1);
    steps(15);
    expect_out(3, "d_edge39", 0, 0, p1(9), tm(0,1), seg(1), 1);
    step();
    expect_out(3, "d_timeout", 1, 0, p1(9), tm(0,0), seg(1), 1);
`ifdef SCOREBOARD_HISCORE_EN
    expect_out(4, "d_hiscore_first", 0, 0, p1(9), '0, '0, 0);
`endif
    start(3);
    repeat (3) pulse(3);
    steps(34);
    expect_out(3, "d_second_game", 1, 0, p1(3), tm(0,0), seg(1), 1);
`ifdef SCOREBOARD_HISCORE_EN
    expect_out(4, "d_hiscore_kept", 0, 0, p1(9), '0, '0, 0);
`endif
    do_reset(3);
    expect_out(3, "d_reset", 0, 0, p1(0), tm(0,1), seg(1), 1);
`ifdef SCOREBOARD_HISCORE_EN
    expect_out(4, "d_hiscore_after_rst", 0, 0, p1(9), '0, '0, 0);
`endif

    steps(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
